// File: rtl/brief_desc_pack.sv
// BRIEF descriptor packer: collects DESC_BITS serial comparison bits into one
// word, tags it with the keypoint coordinates and holds it for a ready/valid sink.
module brief_desc_pack #(
   parameter int DESC_BITS = 256,
   parameter int COORD_W   = 11
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [COORD_W-1:0]   i_x,
   input  logic [COORD_W-1:0]   i_y,
   input  logic                 i_en,
   input  logic                 i_data,
   output logic [DESC_BITS-1:0] o_desc,
   output logic [COORD_W-1:0]   o_x,
   output logic [COORD_W-1:0]   o_y,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_busy,
   output logic                 o_err
);

   localparam int IDX_W = $clog2(DESC_BITS);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DESC_BITS - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt;
   logic             restart;
   logic             take;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_n;
   end

   // restart covers IDLE start, abort in COLLECT and start coincident with a HOLD handshake
   always_comb begin
      state_n = state;
      restart = 1'b0;
      take    = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               restart = 1'b1;
               state_n = COLLECT;
            end
         end
         COLLECT: begin
            if (i_start) begin
               restart = 1'b1;
            end else if (i_en) begin
               take = 1'b1;
               if (cnt == LAST) state_n = HOLD;
            end
         end
         HOLD: begin
            if (i_ready) begin
               if (i_start) begin
                  restart = 1'b1;
                  state_n = COLLECT;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      o_valid = (state == HOLD);
      o_busy  = (state != IDLE);
      o_err   = 1'b0;
      if (state == COLLECT)
         o_err = i_start;
      else if (state == HOLD)
         o_err = i_ready ? (i_en && !i_start) : (i_en || i_start);
   end

   // A start that coincides with i_en takes that bit as bit 0
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_desc <= '0;
         o_x    <= '0;
         o_y    <= '0;
         cnt    <= '0;
      end else if (restart) begin
         o_desc <= {{(DESC_BITS-1){1'b0}}, i_en & i_data};
         o_x    <= i_x;
         o_y    <= i_y;
         cnt    <= {{(CNT_W-1){1'b0}}, i_en};
      end else if (take) begin
         o_desc[cnt[IDX_W-1:0]] <= i_data;
         cnt                    <= cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_brief_desc_pack.sv
// Directed bench for brief_desc_pack: one task per scenario, inline checks
// against hand-computed descriptors and coordinates.
module tb_brief_desc_pack;

   localparam int DB = 256;
   localparam int CW = 11;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic [CW-1:0] i_x = '0;
   logic [CW-1:0] i_y = '0;
   logic          i_en = 1'b0;
   logic          i_data = 1'b0;
   logic          i_ready = 1'b0;
   logic [DB-1:0] o_desc;
   logic [CW-1:0] o_x;
   logic [CW-1:0] o_y;
   logic          o_valid;
   logic          o_busy;
   logic          o_err;

   int n_checks = 0;
   int n_fail   = 0;
   int err_cnt  = 0;
   int vld_cnt  = 0;
   int acc_cnt  = 0;

   brief_desc_pack #(.DESC_BITS(DB), .COORD_W(CW)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (i_start),
      .i_x     (i_x),
      .i_y     (i_y),
      .i_en    (i_en),
      .i_data  (i_data),
      .o_desc  (o_desc),
      .o_x     (o_x),
      .o_y     (o_y),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_busy  (o_busy),
      .o_err   (o_err)
   );

   always #5 i_clk = ~i_clk;

   // Event counters sampled mid-cycle, after inputs have settled
   always @(negedge i_clk) begin
      if (o_err)             err_cnt <= err_cnt + 1;
      if (o_valid)           vld_cnt <= vld_cnt + 1;
      if (o_valid && i_ready) acc_cnt <= acc_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      i_en   = 1'b1;
      i_data = b;
      tick();
      i_en   = 1'b0;
      i_data = 1'b0;
   endtask

   task automatic do_start(input logic [CW-1:0] x, input logic [CW-1:0] y);
      i_start = 1'b1;
      i_x     = x;
      i_y     = y;
      tick();
      i_start = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({o_valid, o_busy, o_err} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 000", {o_valid, o_busy, o_err});
      end
      n_checks++;
      if (o_desc !== '0 || o_x !== '0 || o_y !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got desc=%h x=%0d y=%0d want all 0", o_desc, o_x, o_y);
      end
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();
      n_checks++;
      if (o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b want 0", o_busy);
      end
   endtask

   task automatic test_alternate();
      logic [DB-1:0] exp;
      int v0, e0;
      exp = {128{2'b01}};
      v0 = vld_cnt; e0 = err_cnt;
      i_ready = 1'b1;
      do_start(11'd100, 11'd50);
      n_checks++;
      if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL alt_collect: got busy=%b valid=%b want 1 0", o_busy, o_valid);
      end
      for (int k = 0; k < DB; k++) send_bit(k[0] == 1'b0);
      n_checks++;
      if (o_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL alt_valid: got %b want 1", o_valid);
      end
      n_checks++;
      if (o_desc !== exp || o_x !== 11'd100 || o_y !== 11'd50) begin
         n_fail++;
         $display("FAIL alt_data: got desc=%h x=%0d y=%0d want %h 100 50", o_desc, o_x, o_y, exp);
      end
      tick();
      n_checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || (vld_cnt - v0) != 1 || (err_cnt - e0) != 0) begin
         n_fail++;
         $display("FAIL alt_done: got valid=%b busy=%b vld_cycles=%0d errs=%0d want 0 0 1 0",
                  o_valid, o_busy, vld_cnt - v0, err_cnt - e0);
      end
      i_ready = 1'b0;
   endtask

   task automatic test_gapped_hold();
      logic [DB-1:0] exp;
      int v0, e0;
      exp = '1;
      i_ready = 1'b0;
      do_start(11'd3, 11'd4);
      for (int k = 0; k < DB; k++) begin
         if ($urandom_range(0, 1) == 1) tick();
         send_bit(1'b1);
      end
      v0 = vld_cnt; e0 = err_cnt;
      for (int c = 0; c < 20; c++) begin
         if (c == 5) begin
            i_en = 1'b1; i_data = 1'b0;
         end
         if (c == 10) begin
            i_start = 1'b1; i_x = 11'd9; i_y = 11'd9;
         end
         tick();
         i_en = 1'b0; i_start = 1'b0;
      end
      n_checks++;
      if (o_valid !== 1'b1 || (vld_cnt - v0) != 20) begin
         n_fail++;
         $display("FAIL hold_valid: got valid=%b cycles=%0d want 1 20", o_valid, vld_cnt - v0);
      end
      n_checks++;
      if (o_desc !== exp || o_x !== 11'd3 || o_y !== 11'd4) begin
         n_fail++;
         $display("FAIL hold_stable: got desc=%h x=%0d y=%0d want all-ones 3 4", o_desc, o_x, o_y);
      end
      n_checks++;
      if ((err_cnt - e0) != 2) begin
         n_fail++;
         $display("FAIL hold_err: got %0d err pulses want 2", err_cnt - e0);
      end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      n_checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release: got valid=%b busy=%b want 0 0", o_valid, o_busy);
      end
   endtask

   task automatic test_abort();
      int v0, e0;
      v0 = vld_cnt; e0 = err_cnt;
      i_ready = 1'b1;
      do_start(11'd1, 11'd2);
      for (int k = 0; k < 100; k++) send_bit(1'b1);
      do_start(11'd7, 11'd8);
      for (int k = 0; k < DB; k++) send_bit(1'b0);
      n_checks++;
      if (o_valid !== 1'b1 || o_desc !== '0 || o_x !== 11'd7 || o_y !== 11'd8) begin
         n_fail++;
         $display("FAIL abort_data: got valid=%b desc=%h x=%0d y=%0d want 1 0 7 8",
                  o_valid, o_desc, o_x, o_y);
      end
      tick();
      n_checks++;
      if ((err_cnt - e0) != 1 || (vld_cnt - v0) != 1) begin
         n_fail++;
         $display("FAIL abort_counts: got errs=%0d vld=%0d want 1 1", err_cnt - e0, vld_cnt - v0);
      end
      i_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [DB-1:0] exp1, exp2;
      int e0, a0;
      exp1 = {{128{1'b0}}, {128{1'b1}}};
      exp2 = {128{2'b10}};
      i_ready = 1'b0;
      do_start(11'd20, 11'd21);
      for (int k = 0; k < DB; k++) send_bit(k < 128);
      tick();
      n_checks++;
      if (o_valid !== 1'b1 || o_desc !== exp1 || o_x !== 11'd20) begin
         n_fail++;
         $display("FAIL b2b_first: got valid=%b desc=%h x=%0d want 1 %h 20", o_valid, o_desc, o_x, exp1);
      end
      e0 = err_cnt; a0 = acc_cnt;
      i_ready = 1'b1;
      do_start(11'd30, 11'd31);
      i_ready = 1'b0;
      n_checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b1 || (acc_cnt - a0) != 1 || (err_cnt - e0) != 0) begin
         n_fail++;
         $display("FAIL b2b_switch: got valid=%b busy=%b acc=%0d errs=%0d want 0 1 1 0",
                  o_valid, o_busy, acc_cnt - a0, err_cnt - e0);
      end
      for (int k = 0; k < DB; k++) send_bit(k[0] == 1'b1);
      n_checks++;
      if (o_valid !== 1'b1 || o_desc !== exp2 || o_x !== 11'd30 || o_y !== 11'd31) begin
         n_fail++;
         $display("FAIL b2b_second: got valid=%b desc=%h x=%0d y=%0d want 1 %h 30 31",
                  o_valid, o_desc, o_x, o_y, exp2);
      end
      // bit arriving in the handshake cycle is dropped and flagged
      i_ready = 1'b1;
      send_bit(1'b1);
      i_ready = 1'b0;
      n_checks++;
      if ((err_cnt - e0) != 1 || o_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_drop: got errs=%0d busy=%b want 1 0", err_cnt - e0, o_busy);
      end
   endtask

   task automatic test_reset_mid();
      int v0;
      i_ready = 1'b1;
      do_start(11'd77, 11'd66);
      for (int k = 0; k < 200; k++) send_bit(1'b1);
      #2;
      i_rst_n = 1'b0;
      #1;
      n_checks++;
      if (o_desc !== '0 || o_x !== '0 || o_y !== '0 || {o_valid, o_busy, o_err} !== 3'b000) begin
         n_fail++;
         $display("FAIL rst_async: got desc=%h x=%0d y=%0d flags=%b want all 0",
                  o_desc, o_x, o_y, {o_valid, o_busy, o_err});
      end
      tick();
      i_rst_n = 1'b1;
      tick();
      v0 = vld_cnt;
      for (int k = 0; k < DB; k++) send_bit(1'b1);
      tick();
      n_checks++;
      if ((vld_cnt - v0) != 0 || o_busy !== 1'b0 || o_desc !== '0) begin
         n_fail++;
         $display("FAIL rst_idle_en: got vld=%0d busy=%b desc=%h want 0 0 0", vld_cnt - v0, o_busy, o_desc);
      end
      i_ready = 1'b0;
   endtask

   task automatic test_start_with_bit();
      logic [DB-1:0] exp;
      exp = {{(DB-1){1'b0}}, 1'b1};
      i_ready = 1'b0;
      i_en = 1'b1;
      i_data = 1'b1;
      do_start(11'd5, 11'd6);
      i_en = 1'b0;
      i_data = 1'b0;
      for (int k = 0; k < DB - 1; k++) send_bit(1'b0);
      n_checks++;
      if (o_valid !== 1'b1 || o_desc !== exp || o_x !== 11'd5) begin
         n_fail++;
         $display("FAIL start_bit0: got valid=%b desc=%h x=%0d want 1 %h 5", o_valid, o_desc, o_x, exp);
      end
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_gapped_hold();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      test_start_with_bit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
